// File: rtl/gte_mvmva_sequencer.sv
// Sequences one MVMVA-style 3x3 matrix x vector op over the shared GTE select/multiply path.
// Optional IR saturation outputs are built when GTE_MVMVA_IRSAT_EN is defined.
module gte_mvmva_sequencer #(
    parameter int PROD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_start,
    input  logic [1:0]  i_mx,
    input  logic [1:0]  i_vec,
    input  logic        i_sf,
    input  logic        i_transEn,
    input  logic [31:0] i_trans0,
    input  logic [31:0] i_trans1,
    input  logic [31:0] i_trans2,
    input  logic [34:0] i_product,
`ifdef GTE_MVMVA_IRSAT_EN
    input  logic        i_lm,
    output logic [15:0] o_ir0,
    output logic [15:0] o_ir1,
    output logic [15:0] o_ir2,
    output logic [2:0]  o_irSat,
`endif
    output logic        o_busy,
    output logic        o_done,
    output logic        o_isMVMVA,
    output logic [1:0]  o_mx,
    output logic [1:0]  o_vec,
    output logic [1:0]  o_row,
    output logic [1:0]  o_col,
    output logic [3:0]  o_selLeft,
    output logic [3:0]  o_selRight,
    output logic [31:0] o_mac0,
    output logic [31:0] o_mac1,
    output logic [31:0] o_mac2,
    output logic [2:0]  o_ovfPos,
    output logic [2:0]  o_ovfNeg
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINAL, S_DONE} state_t;

    localparam logic signed [45:0] LIM_POS    = (46'sd1 <<< 43) - 46'sd1;
    localparam logic signed [45:0] LIM_NEG    = -(46'sd1 <<< 43);
    localparam logic [1:0]         DRAIN_LAST = (PROD_LAT > 0) ? 2'(PROD_LAT - 1) : 2'd0;

    state_t             r_state;
    logic [3:0]         r_k;
    logic [1:0]         r_dcnt;
    logic               r_sf;
    logic signed [45:0] r_acc [3];

    logic               w_issue;
    logic               w_acc_vld;
    logic [1:0]         w_acc_row;
    logic [31:0]        w_trans [3];
    logic signed [45:0] w_pre [3];
    logic signed [45:0] w_shr [3];
    logic [31:0]        w_mac [3];
    logic signed [45:0] w_prod_ext;
    logic signed [45:0] w_acc_sum;

    assign w_issue    = (r_state == S_ISSUE);
    assign o_selRight = 4'd0;
    assign w_trans[0] = i_trans0;
    assign w_trans[1] = i_trans1;
    assign w_trans[2] = i_trans2;
    assign w_prod_ext = {{11{i_product[34]}}, i_product};
    assign w_acc_sum  = r_acc[w_acc_row] + w_prod_ext;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_pre[r] = i_transEn ? {{2{w_trans[r][31]}}, w_trans[r], 12'd0} : 46'sd0;
            w_shr[r] = r_acc[r] >>> 12;
            w_mac[r] = r_sf ? w_shr[r][31:0] : r_acc[r][31:0];
        end
    end

    // Row tag travels with the valid bit so each returning product lands in its own accumulator.
    generate
        if (PROD_LAT == 0) begin : g_nopipe
            assign w_acc_vld = w_issue;
            assign w_acc_row = o_row;
        end else begin : g_pipe
            logic [PROD_LAT-1:0] r_vld_pipe;
            logic [1:0]          r_row_pipe [PROD_LAT];
            always_ff @(posedge i_clk or negedge i_nRst) begin
                if (!i_nRst) begin
                    r_vld_pipe <= '0;
                    for (int i = 0; i < PROD_LAT; i++) r_row_pipe[i] <= 2'd0;
                end else begin
                    r_vld_pipe[0] <= w_issue;
                    r_row_pipe[0] <= o_row;
                    for (int i = 1; i < PROD_LAT; i++) begin
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                        r_row_pipe[i] <= r_row_pipe[i-1];
                    end
                end
            end
            assign w_acc_vld = r_vld_pipe[PROD_LAT-1];
            assign w_acc_row = r_row_pipe[PROD_LAT-1];
        end
    endgenerate

`ifdef GTE_MVMVA_IRSAT_EN
    logic              r_lm;
    logic [15:0]       w_ir [3];
    logic [2:0]        w_irSat;
    logic signed [31:0] w_lo;
    always_comb begin
        w_lo    = r_lm ? 32'sd0 : -32'sd32768;
        w_irSat = 3'd0;
        for (int r = 0; r < 3; r++) begin
            w_ir[r] = w_mac[r][15:0];
            if ($signed(w_mac[r]) > 32'sd32767) begin
                w_ir[r]    = 16'h7FFF;
                w_irSat[r] = 1'b1;
            end else if ($signed(w_mac[r]) < w_lo) begin
                w_ir[r]    = w_lo[15:0];
                w_irSat[r] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_state   <= S_IDLE;
            r_k       <= 4'd0;
            r_dcnt    <= 2'd0;
            r_sf      <= 1'b0;
            for (int r = 0; r < 3; r++) r_acc[r] <= 46'sd0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_isMVMVA <= 1'b0;
            o_mx      <= 2'd0;
            o_vec     <= 2'd0;
            o_row     <= 2'd0;
            o_col     <= 2'd0;
            o_selLeft <= 4'd0;
            o_mac0    <= 32'd0;
            o_mac1    <= 32'd0;
            o_mac2    <= 32'd0;
            o_ovfPos  <= 3'd0;
            o_ovfNeg  <= 3'd0;
`ifdef GTE_MVMVA_IRSAT_EN
            r_lm      <= 1'b0;
            o_ir0     <= 16'd0;
            o_ir1     <= 16'd0;
            o_ir2     <= 16'd0;
            o_irSat   <= 3'd0;
`endif
        end else begin
            if (w_acc_vld) begin
                r_acc[w_acc_row] <= w_acc_sum;
                if (w_acc_sum > LIM_POS) o_ovfPos[w_acc_row] <= 1'b1;
                if (w_acc_sum < LIM_NEG) o_ovfNeg[w_acc_row] <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state   <= S_ISSUE;
                    r_k       <= 4'd0;
                    r_sf      <= i_sf;
                    o_mx      <= i_mx;
                    o_vec     <= i_vec;
                    o_busy    <= 1'b1;
                    o_isMVMVA <= 1'b1;
                    o_row     <= 2'd0;
                    o_col     <= 2'd0;
                    o_selLeft <= 4'd0;
`ifdef GTE_MVMVA_IRSAT_EN
                    r_lm      <= i_lm;
`endif
                    for (int r = 0; r < 3; r++) begin
                        r_acc[r]    <= w_pre[r];
                        o_ovfPos[r] <= (w_pre[r] > LIM_POS);
                        o_ovfNeg[r] <= (w_pre[r] < LIM_NEG);
                    end
                end
                S_ISSUE: begin
                    if (r_k == 4'd8) begin
                        o_isMVMVA <= 1'b0;
                        o_row     <= 2'd0;
                        o_col     <= 2'd0;
                        o_selLeft <= 4'd0;
                        r_dcnt    <= 2'd0;
                        r_state   <= (PROD_LAT == 0) ? S_FINAL : S_DRAIN;
                    end else begin
                        r_k <= r_k + 4'd1;
                        if (o_col == 2'd2) begin
                            o_col     <= 2'd0;
                            o_selLeft <= 4'd0;
                            o_row     <= o_row + 2'd1;
                        end else begin
                            o_col     <= o_col + 2'd1;
                            o_selLeft <= {2'b00, o_col + 2'd1};
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DRAIN_LAST) r_state <= S_FINAL;
                    else                      r_dcnt  <= r_dcnt + 2'd1;
                end
                S_FINAL: begin
                    o_mac0  <= w_mac[0];
                    o_mac1  <= w_mac[1];
                    o_mac2  <= w_mac[2];
`ifdef GTE_MVMVA_IRSAT_EN
                    o_ir0   <= w_ir[0];
                    o_ir1   <= w_ir[1];
                    o_ir2   <= w_ir[2];
                    o_irSat <= w_irSat;
`endif
                    o_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gte_mvmva_sequencer.sv
// Randomized self-checking bench for gte_mvmva_sequencer with a behavioural select-path model.
module tb_gte_mvmva_sequencer;
    localparam int LAT = 1;

    logic        i_clk = 1'b0, i_nRst = 1'b0, i_start = 1'b0;
    logic [1:0]  i_mx = '0, i_vec = '0;
    logic        i_sf = 1'b0, i_transEn = 1'b0;
    logic [31:0] i_trans0 = '0, i_trans1 = '0, i_trans2 = '0;
    logic [34:0] i_product = '0;
    logic        o_busy, o_done, o_isMVMVA;
    logic [1:0]  o_mx, o_vec, o_row, o_col;
    logic [3:0]  o_selLeft, o_selRight;
    logic [31:0] o_mac0, o_mac1, o_mac2;
    logic [2:0]  o_ovfPos, o_ovfNeg;
`ifdef GTE_MVMVA_IRSAT_EN
    logic        i_lm = 1'b0;
    logic [15:0] o_ir0, o_ir1, o_ir2;
    logic [2:0]  o_irSat;
`endif

    gte_mvmva_sequencer #(.PROD_LAT(LAT)) dut (
        .i_clk(i_clk), .i_nRst(i_nRst), .i_start(i_start), .i_mx(i_mx), .i_vec(i_vec),
        .i_sf(i_sf), .i_transEn(i_transEn), .i_trans0(i_trans0), .i_trans1(i_trans1),
        .i_trans2(i_trans2), .i_product(i_product),
`ifdef GTE_MVMVA_IRSAT_EN
        .i_lm(i_lm), .o_ir0(o_ir0), .o_ir1(o_ir1), .o_ir2(o_ir2), .o_irSat(o_irSat),
`endif
        .o_busy(o_busy), .o_done(o_done), .o_isMVMVA(o_isMVMVA), .o_mx(o_mx), .o_vec(o_vec),
        .o_row(o_row), .o_col(o_col), .o_selLeft(o_selLeft), .o_selRight(o_selRight),
        .o_mac0(o_mac0), .o_mac1(o_mac1), .o_mac2(o_mac2), .o_ovfPos(o_ovfPos), .o_ovfNeg(o_ovfNeg)
    );

    always #5 i_clk = ~i_clk;

    int M [3][3];
    int V [3];
    int tr [3];
    bit te, sf, lm;
    logic [1:0] mx, vec;
    logic [31:0] em [3];
    logic [2:0] ep, en;
    int n_total = 0, n_bad = 0;

    // Select path: returns M[row][col]*V[col] one cycle after the step is issued.
    always @(posedge i_clk) begin
        if (o_isMVMVA) i_product <= 35'(longint'(M[o_row][o_col]) * longint'(V[o_col]));
        else           i_product <= '0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rs16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    // Reference: sum in plain 64-bit arithmetic, overflow checked after every partial sum.
    task automatic ref_op();
        longint acc, lp, ln;
        lp = (longint'(1) <<< 43) - 1;
        ln = -(longint'(1) <<< 43);
        for (int r = 0; r < 3; r++) begin
            acc = te ? longint'(tr[r]) * 4096 : 0;
            ep[r] = (acc > lp);
            en[r] = (acc < ln);
            for (int c = 0; c < 3; c++) begin
                acc = acc + longint'(M[r][c]) * longint'(V[c]);
                if (acc > lp) ep[r] = 1'b1;
                if (acc < ln) en[r] = 1'b1;
            end
            em[r] = sf ? 32'(acc >>> 12) : 32'(acc);
        end
    endtask

    task automatic drive_start();
        @(negedge i_clk);
        i_mx = mx; i_vec = vec; i_sf = sf; i_transEn = te;
        i_trans0 = 32'(tr[0]); i_trans1 = 32'(tr[1]); i_trans2 = 32'(tr[2]);
`ifdef GTE_MVMVA_IRSAT_EN
        i_lm = lm;
`endif
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic run_op(input string name, input bit repulse);
        int done_cyc, ndone, seq_err;
        bit exp_mv;
        done_cyc = -1; ndone = 0; seq_err = 0;
        drive_start();
        for (int cyc = 1; cyc <= LAT + 16; cyc++) begin
            exp_mv = (cyc <= 9);
            if (o_isMVMVA !== exp_mv || o_selRight !== 4'd0 || o_busy !== (cyc <= LAT + 11)) seq_err++;
            if (exp_mv && (o_row !== 2'((cyc - 1) / 3) || o_col !== 2'((cyc - 1) % 3) ||
                           o_selLeft !== {2'b00, 2'((cyc - 1) % 3)})) seq_err++;
            if (!exp_mv && (o_row !== 2'd0 || o_col !== 2'd0 || o_selLeft !== 4'd0)) seq_err++;
            if (o_done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            i_start = repulse && (cyc == 3 || cyc == LAT + 11);
            @(negedge i_clk);
        end
        i_start = 1'b0;
        ref_op();
        chk({name, "_donecyc"}, 64'(done_cyc), 64'(LAT + 11));
        chk({name, "_ndone"}, 64'(ndone), 64'd1);
        chk({name, "_seq"}, 64'(seq_err), 64'd0);
        chk({name, "_mac0"}, o_mac0, em[0]);
        chk({name, "_mac1"}, o_mac1, em[1]);
        chk({name, "_mac2"}, o_mac2, em[2]);
        chk({name, "_ovfPos"}, o_ovfPos, ep);
        chk({name, "_ovfNeg"}, o_ovfNeg, en);
        chk({name, "_mxvec"}, {o_mx, o_vec}, {mx, vec});
`ifdef GTE_MVMVA_IRSAT_EN
        begin
            logic [15:0] eir [3];
            logic [2:0]  esat;
            int lo;
            lo = lm ? 0 : -32768;
            for (int r = 0; r < 3; r++) begin
                esat[r] = 1'b1;
                if (int'($signed(em[r])) > 32767)   eir[r] = 16'h7FFF;
                else if (int'($signed(em[r])) < lo) eir[r] = 16'(lo);
                else begin eir[r] = em[r][15:0]; esat[r] = 1'b0; end
            end
            chk({name, "_ir0"}, o_ir0, eir[0]);
            chk({name, "_ir1"}, o_ir1, eir[1]);
            chk({name, "_ir2"}, o_ir2, eir[2]);
            chk({name, "_irSat"}, o_irSat, esat);
        end
`endif
    endtask

    task automatic setup_diag(input int v0, input int v1, input int v2);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) M[r][c] = (r == c) ? 4096 : 0;
        V[0] = v0; V[1] = v1; V[2] = v2;
        tr[0] = 0; tr[1] = 0; tr[2] = 0;
        te = 0; sf = 1; mx = 2'd1; vec = 2'd3; lm = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, {o_busy, o_done, o_isMVMVA}, 64'd0);
        chk({name, "_path"}, {o_mx, o_vec, o_row, o_col, o_selLeft, o_selRight}, 64'd0);
        chk({name, "_mac"}, {o_mac0, o_mac1}, 64'd0);
        chk({name, "_mac2ovf"}, {o_mac2, o_ovfPos, o_ovfNeg}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_nRst = 1'b1;

        setup_diag(100, 200, 300);
        run_op("t1", 1'b0);
        chk("t1_abs", {o_mac0, o_mac1}, {32'd100, 32'd200});

        te = 1; tr[0] = 1; tr[1] = -2; tr[2] = 3;
        run_op("t2", 1'b0);
        chk("t2_abs", {o_mac1, o_mac2}, {32'd198, 32'd303});

        for (int r = 0; r < 3; r++) begin
            V[r] = 32767;
            for (int c = 0; c < 3; c++) M[r][c] = 32767;
        end
        tr[0] = 32'h7FFF_FFFF; tr[1] = 0; tr[2] = 0; te = 1; sf = 0;
        run_op("t3", 1'b0);
        chk("t3_ovfPos_abs", o_ovfPos, 3'b001);

        for (int r = 0; r < 3; r++) begin
            V[r] = -32768; tr[r] = int'(32'h8000_0000);
        end
        sf = 1;
        run_op("t3neg", 1'b0);
        chk("t3neg_ovfNeg_abs", o_ovfNeg, 3'b111);

        setup_diag(100, 200, 300);
        run_op("t4", 1'b1);

        setup_diag(7, 8, 9);
        drive_start();
        repeat (4) @(negedge i_clk);
        i_nRst = 1'b0;
        #1;
        chk_zero("t5rst");
        @(negedge i_clk);
        i_nRst = 1'b1;
        setup_diag(100, 200, 300);
        run_op("t5", 1'b0);
        chk("t5_abs", o_mac2, 32'd300);

        for (int n = 0; n < 20; n++) begin
            for (int r = 0; r < 3; r++) begin
                V[r] = rs16();
                tr[r] = int'($urandom);
                for (int c = 0; c < 3; c++) M[r][c] = rs16();
            end
            te = 1'($urandom); sf = 1'($urandom); lm = 1'($urandom);
            mx = 2'($urandom); vec = 2'($urandom);
            run_op($sformatf("rnd%0d", n), 1'($urandom));
        end

`ifdef GTE_MVMVA_IRSAT_EN
        setup_diag(-5, 0, 7);
        te = 1; tr[1] = 40000; lm = 1;
        run_op("t6lm1", 1'b0);
        chk("t6_ir_abs", {o_ir0, o_ir1, o_ir2, 13'd0, o_irSat}, {16'd0, 16'd32767, 16'd7, 16'd3});
        lm = 0;
        run_op("t6lm0", 1'b0);
        chk("t6_ir0_abs", o_ir0, 16'hFFFB);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
